// File: rtl/counter_sequencer.sv
// Start/stop/pause sequencer for a prescaled WIDTH-bit counter with terminal compare,
// supporting one-shot and auto-reload modes; all outputs are registered.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           cur_state, nxt_state;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] term_shadow;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [PRE_W-1:0] pre_shadow;
  logic             reload_shadow;
  logic             tc_nxt;
  logic             load_cfg;
  logic             tick;

  assign tick  = (cur_state == RUN) && (pre_cnt == pre_shadow);
  assign state = cur_state;

  // Priority inside each state: stop > start > pause > tick.
  always_comb begin
    nxt_state = cur_state;
    q_nxt     = q;
    pre_nxt   = pre_cnt;
    tc_nxt    = 1'b0;
    load_cfg  = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start) begin
          nxt_state = RUN;
          q_nxt     = '0;
          pre_nxt   = '0;
          load_cfg  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          nxt_state = IDLE;
          q_nxt     = '0;
          pre_nxt   = '0;
        end else if (pause) begin
          nxt_state = PAUSE;
        end else if (tick) begin
          pre_nxt = '0;
          if (q != term_shadow) begin
            q_nxt = q + 1'b1;
          end else begin
            tc_nxt = 1'b1;
            if (reload_shadow) q_nxt = '0;
            else               nxt_state = DONE;
          end
        end else begin
          pre_nxt = pre_cnt + 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          nxt_state = IDLE;
          q_nxt     = '0;
          pre_nxt   = '0;
        end else if (!pause) begin
          nxt_state = RUN;
        end
      end
      DONE: begin
        if (stop) begin
          nxt_state = IDLE;
          q_nxt     = '0;
          pre_nxt   = '0;
        end else if (start) begin
          nxt_state = RUN;
          q_nxt     = '0;
          pre_nxt   = '0;
          load_cfg  = 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        q_nxt     = '0;
        pre_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state     <= IDLE;
      q             <= '0;
      pre_cnt       <= '0;
      tc            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      term_shadow   <= '0;
      pre_shadow    <= '0;
      reload_shadow <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      q         <= q_nxt;
      pre_cnt   <= pre_nxt;
      tc        <= tc_nxt;
      busy      <= (nxt_state == RUN) || (nxt_state == PAUSE);
      done      <= (nxt_state == DONE);
      if (load_cfg) begin
        term_shadow   <= term;
        pre_shadow    <= prescale;
        reload_shadow <= auto_reload;
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: each scenario task drives stimulus and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, auto_reload;
  logic [7:0] prescale;
  logic [3:0] term;
  logic [3:0] q;
  logic       busy, tc, done;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  counter_sequencer #(.WIDTH(4), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .prescale(prescale), .term(term),
    .q(q), .busy(busy), .tc(tc), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] t, input logic ar);
    prescale = p; term = t; auto_reload = ar;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    auto_reload = 1'b0; prescale = 8'd0; term = 4'd0;
    step(); step();
    checks++;
    if (state !== 2'd0 || q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d q=%0d busy=%b tc=%b done=%b, required 0 0 0 0 0", state, q, busy, tc, done);
    end
    rst = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd0) begin
      errors++;
      $display("FAIL idle_stop: state=%0d q=%0d, required 0 0", state, q);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(8'd0, 4'd9, 1'b0);
    repeat (5) step();
    checks++;
    if (q !== 4'd5 || state !== 2'd1) begin
      errors++;
      $display("FAIL run_to_5: q=%0d state=%0d, required 5 1", q, state);
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if (q !== 4'd0 || state !== 2'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: q=%0d state=%0d busy=%b tc=%b, required 0 0 0 0", q, state, busy, tc);
    end
  endtask

  task automatic test_one_shot();
    launch(8'd0, 4'd9, 1'b0);
    checks++;
    if (q !== 4'd0 || state !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL one_shot_enter: q=%0d state=%0d busy=%b, required 0 1 1", q, state, busy);
    end
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (q !== 4'(i) || tc !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL one_shot_count[%0d]: q=%0d tc=%b done=%b, required %0d 0 0", i, q, tc, done, i);
      end
    end
    step();
    checks++;
    if (tc !== 1'b1 || done !== 1'b1 || state !== 2'd3 || q !== 4'd9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL one_shot_term: tc=%b done=%b state=%0d q=%0d busy=%b, required 1 1 3 9 0", tc, done, state, q, busy);
    end
    step();
    checks++;
    if (tc !== 1'b0 || done !== 1'b1 || q !== 4'd9) begin
      errors++;
      $display("FAIL one_shot_hold: tc=%b done=%b q=%0d, required 0 1 9", tc, done, q);
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_stop: state=%0d q=%0d done=%b, required 0 0 0", state, q, done);
    end
  endtask

  task automatic test_reload_prescaler();
    logic [3:0] exp_q;
    logic       exp_tc;
    launch(8'd2, 4'd3, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      step();
      exp_q  = 4'((k / 3) % 4);
      exp_tc = (k % 12 == 0);
      checks++;
      if (q !== exp_q || tc !== exp_tc || state !== 2'd1) begin
        errors++;
        $display("FAIL reload[%0d]: q=%0d tc=%b state=%0d, required %0d %b 1", k, q, tc, state, exp_q, exp_tc);
      end
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reload_stop: state=%0d q=%0d busy=%b, required 0 0 0", state, q, busy);
    end
  endtask

  task automatic test_pause();
    launch(8'd3, 4'd15, 1'b0);
    repeat (4) step();
    checks++;
    if (q !== 4'd1) begin
      errors++;
      $display("FAIL pause_first_inc: q=%0d, required 1", q);
    end
    repeat (2) step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      step();
      checks++;
      if (q !== 4'd1 || state !== 2'd2 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold[%0d]: q=%0d state=%0d busy=%b, required 1 2 1", i, q, state, busy);
      end
    end
    start = 1'b0; pause = 1'b0;
    step();
    checks++;
    if (state !== 2'd1 || q !== 4'd1) begin
      errors++;
      $display("FAIL resume: state=%0d q=%0d, required 1 1", state, q);
    end
    step();
    checks++;
    if (q !== 4'd1) begin
      errors++;
      $display("FAIL resume_phase_a: q=%0d, required 1", q);
    end
    step();
    checks++;
    if (q !== 4'd2) begin
      errors++;
      $display("FAIL resume_phase_b: q=%0d, required 2", q);
    end
    pause = 1'b1; step(); pause = 1'b0;
    stop = 1'b1; pause = 1'b1; step(); stop = 1'b0; pause = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd0) begin
      errors++;
      $display("FAIL pause_stop: state=%0d q=%0d, required 0 0", state, q);
    end
  endtask

  task automatic test_simultaneous();
    launch(8'd0, 4'd9, 1'b0);
    repeat (3) step();
    start = 1'b1; term = 4'd2; step(); start = 1'b0;
    checks++;
    if (q !== 4'd4 || state !== 2'd1) begin
      errors++;
      $display("FAIL start_in_run: q=%0d state=%0d, required 4 1", q, state);
    end
    repeat (5) step();
    checks++;
    if (q !== 4'd9 || done !== 1'b0) begin
      errors++;
      $display("FAIL term_change_ignored: q=%0d done=%b, required 9 0", q, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || tc !== 1'b1) begin
      errors++;
      $display("FAIL term_shadow_done: done=%b tc=%b, required 1 1", done, tc);
    end
    launch(8'd0, 4'd9, 1'b0);
    step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++;
    if (state !== 2'd0 || q !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_run: state=%0d q=%0d busy=%b, required 0 0 0", state, q, busy);
    end
  endtask

  task automatic test_edges();
    launch(8'd0, 4'd0, 1'b0);
    step();
    checks++;
    if (tc !== 1'b1 || done !== 1'b1 || q !== 4'd0 || state !== 2'd3) begin
      errors++;
      $display("FAIL term0_oneshot: tc=%b done=%b q=%0d state=%0d, required 1 1 0 3", tc, done, q, state);
    end
    step();
    checks++;
    if (tc !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL term0_single_pulse: tc=%b done=%b, required 0 1", tc, done);
    end
    launch(8'd0, 4'd15, 1'b1);
    checks++;
    if (state !== 2'd1 || q !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_from_done: state=%0d q=%0d done=%b, required 1 0 0", state, q, done);
    end
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++;
      if (q !== 4'(i) || tc !== 1'b0) begin
        errors++;
        $display("FAIL term15_count[%0d]: q=%0d tc=%b, required %0d 0", i, q, tc, i);
      end
    end
    step();
    checks++;
    if (q !== 4'd0 || tc !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL term15_wrap: q=%0d tc=%b state=%0d, required 0 1 1", q, tc, state);
    end
    step();
    checks++;
    if (q !== 4'd1 || tc !== 1'b0) begin
      errors++;
      $display("FAIL term15_after: q=%0d tc=%b, required 1 0", q, tc);
    end
    stop = 1'b1; step(); stop = 1'b0;
    launch(8'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (tc !== 1'b1 || q !== 4'd0 || state !== 2'd1) begin
        errors++;
        $display("FAIL term0_reload[%0d]: tc=%b q=%0d state=%0d, required 1 0 1", i, tc, q, state);
      end
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_one_shot();
    test_reload_prescaler();
    test_pause();
    test_simultaneous();
    test_edges();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Programmable controller that sequences a WIDTH-bit counting datapath for homework-lab timing tasks. It provides start/stop/pause control, a prescaler-gated count enable, a terminal-count compare, and one-shot or auto-reload modes. The counter register is held internally, so the block is fully synchronous, with a single clock domain and no rippled clocks. Its outputs drive LED/seven-segment displays and event pulses to neighbouring lab blocks.

Parameters:
WIDTH, 4, counter width in bits
PRE_W, 8, prescaler width in bits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begin counting from 0
stop  input  1  single-cycle pulse; abort and return to IDLE
pause  input  1  level; while high in RUN, counting is frozen
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode
prescale  input  PRE_W  count advances once every prescale+1 clk cycles
term  input  WIDTH  terminal value
q  output  WIDTH  current count
busy  output  1  high in RUN or PAUSE
tc  output  1  one-cycle pulse when the count reaches term
done  output  1  level; high in DONE state (one-shot finished)
state  output  2  encoded FSM state (IDLE=0, RUN=1, PAUSE=2, DONE=3)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: on the rising edge with rst=1, every output is cleared: state=IDLE, q=0, the prescaler counter=0, busy=0, tc=0, done=0. rst has priority over all other inputs.
- Configuration sampling: term, prescale and auto_reload are sampled into shadow registers on the accepted start. Later changes to these inputs have no effect until the next start.
- Tick generation:
  - The prescaler counter runs only in RUN.
  - tick=1 on the cycle the prescaler equals the shadow prescale value; the prescaler then returns to 0.
  - With prescale=0, tick is asserted every RUN cycle.
- IDLE:
  - start=1 -> RUN on the next cycle. q is cleared to 0 and the prescaler is cleared.
  - stop has no effect.
- RUN:
  - On each tick, if q != term_shadow, then q <= q+1.
  - If q == term_shadow on a tick, then tc is pulsed for one cycle in the next cycle. After that:
    - Reload mode: q <= 0 and the FSM stays in RUN.
    - One-shot mode: q holds its value and the FSM goes to DONE.
  - Latency from start to first increment = prescale+1 cycles after entering RUN.
  - pause=1 -> PAUSE. q and the prescaler are frozen at their values.
  - stop=1 -> IDLE. q is cleared.
- PAUSE:
  - pause=0 -> RUN. Counting resumes with no lost prescaler phase.
  - stop -> IDLE with q cleared.
  - start is ignored.
- DONE:
  - done=1 and q holds term_shadow.
  - start -> RUN, with q=0 and fresh configuration sampling.
  - stop -> IDLE with q cleared.
- Priority when several inputs are active in the same cycle: rst > stop > start > pause > tick.
  - stop and start together in RUN -> IDLE.
  - start while in RUN is ignored, i.e. there is no restart.
- term_shadow=0:
  - The first tick produces tc.
  - One-shot: DONE follows immediately.
  - Reload: tc pulses on every tick.
- Wrap-around: q never exceeds term_shadow, so the counter cannot overflow. With term = 2^WIDTH-1 the count reloads to 0 via the terminal compare, not via natural wrap.
- Outputs: tc, q, done and busy are registered. None of them has a combinational path from any input.

Test Plan:
- Reset mid-RUN: start, run to q=5, assert rst for 1 cycle -> next cycle q=0, state=IDLE, busy=0, tc=0.
- One-shot: prescale=0, term=9, auto_reload=0, start -> q goes 1..9 on consecutive cycles, tc pulses once, then done=1, q holds 9, busy=0.
- Reload with prescaler: prescale=2, term=3, auto_reload=1 -> q increments every 3 cycles through 0,1,2,3,0 …; tc pulses every 12 cycles; state stays RUN.
- Pause/resume: prescale=3, pause mid-interval for 10 cycles -> q and the prescaler are frozen; after release, the next increment occurs after the remaining prescaler phase, not a full period.
- Simultaneous events: start+stop together in RUN -> IDLE, q=0. start alone in RUN -> ignored. New term presented mid-RUN -> ignored until the next start from DONE/IDLE.
- Edge values: term=0, one-shot -> one tc pulse then DONE with q=0. term=15 (WIDTH=4), reload -> 15 returns to 0 with a tc pulse and no glitch.
